// File: rtl/fifo_mxn_stream_pkg.sv
// Shared constants and parameter checks for the fifo_mxn_stream block.
// Holds strobe-mode encodings, count width rule and threshold range checks.
package fifo_pkg;

  localparam int STROBE_LEVEL = 0;
  localparam int STROBE_FALL  = 1;

  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

  function automatic bit afull_ok(input int thr, input int aw);
    return (thr >= 1) && (thr <= (1 << aw));
  endfunction

  function automatic bit aempty_ok(input int thr, input int aw);
    return (thr >= 0) && (thr <= (1 << aw) - 1);
  endfunction

  function automatic bit mode_ok(input int m);
    return (m == STROBE_LEVEL) || (m == STROBE_FALL);
  endfunction

endpackage

// File: rtl/fifo_mxn_stream_if.sv
// Bus-side bundle of fifo_mxn_stream: push/pop strobes, data and status.
// FIFO_ERR_FLAGS_EN adds sticky ovf/udf error flags.
interface fifo_mxn_stream_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          ien;
  logic [DW-1:0] idat;
  logic          oen;
  logic [DW-1:0] odat;
  logic          odat_vld;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic [AW:0]   level;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ovf;
  logic          udf;
`endif

  modport master (
    output ien, idat, oen,
    input  odat, odat_vld, full, empty,
    input  afull, aempty, level
`ifdef FIFO_ERR_FLAGS_EN
   ,input  ovf, udf
`endif
  );

  modport slave (
    input  ien, idat, oen,
    output odat, odat_vld, full, empty,
    output afull, aempty, level
`ifdef FIFO_ERR_FLAGS_EN
   ,output ovf, udf
`endif
  );

endinterface

// File: rtl/fifo_mxn_stream_strobe_evt.sv
// Turns a bus request into a push/pop event: level-qualified or
// falling-edge (one cycle later, from a sampled history bit).
module fifo_strobe_evt
  import fifo_pkg::*;
#(
  parameter int STROBE_MODE = STROBE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic evt
);

  logic req_q;

  always_ff @(posedge clk) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= req;
  end

  assign evt = (STROBE_MODE == STROBE_FALL)
             ? (req_q & ~req)
             : req;

endmodule

// File: rtl/fifo_mxn_stream.sv
// Parametrised stream FIFO, full 2^AW depth usable, registered pop data.
// Optional FIFO_ERR_FLAGS_EN adds sticky ovf/udf flags.
module fifo_mxn_stream
  import fifo_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 4,
  parameter int AFULL_THR   = 12,
  parameter int AEMPTY_THR  = 2,
  parameter int STROBE_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  fifo_mxn_stream_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = cnt_w(AW);

  generate
    if (!afull_ok(AFULL_THR, AW)) begin : g_bad_afull
      $error("fifo_mxn_stream: AFULL_THR out of range");
    end
    if (!aempty_ok(AEMPTY_THR, AW)) begin : g_bad_aempty
      $error("fifo_mxn_stream: AEMPTY_THR out of range");
    end
    if (!mode_ok(STROBE_MODE)) begin : g_bad_mode
      $error("fifo_mxn_stream: STROBE_MODE out of range");
    end
  endgenerate

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic push_evt;
  logic pop_evt;
  logic push_acc;
  logic pop_acc;
  logic is_full;
  logic is_empty;

  fifo_strobe_evt #(.STROBE_MODE(STROBE_MODE)) u_push_evt (
    .clk (clk),
    .rst (rst),
    .req (bus.ien),
    .evt (push_evt)
  );

  fifo_strobe_evt #(.STROBE_MODE(STROBE_MODE)) u_pop_evt (
    .clk (clk),
    .rst (rst),
    .req (bus.oen),
    .evt (pop_evt)
  );

  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

  // Pop frees a slot in the same edge, so a full FIFO can still take a push
  assign pop_acc  = pop_evt & ~is_empty;
  assign push_acc = push_evt & (~is_full | pop_acc);

  assign bus.full   = is_full;
  assign bus.empty  = is_empty;
  assign bus.afull  = (count >= CW'(AFULL_THR));
  assign bus.aempty = (count <= CW'(AEMPTY_THR));
  assign bus.level  = count;

  always_ff @(posedge clk) begin
    if (!rst && !clr && push_acc) mem[wptr] <= bus.idat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.odat     <= '0;
      bus.odat_vld <= 1'b0;
    end else if (clr) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.odat_vld <= 1'b0;
    end else begin
      bus.odat_vld <= pop_acc;
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc) begin
        bus.odat <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bus.ovf <= 1'b0;
      bus.udf <= 1'b0;
    end else begin
      bus.ovf <= bus.ovf | (push_evt & ~push_acc);
      bus.udf <= bus.udf | (pop_evt & ~pop_acc);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_mxn_stream.sv
// Scoreboard bench for fifo_mxn_stream: level-mode and falling-edge instances.
// Expected pop data is queued at push time and popped by a monitor.
module tb_fifo_mxn_stream;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;

  fifo_mxn_stream_if #(.DW(8), .AW(4)) f0 ();
  fifo_mxn_stream_if #(.DW(8), .AW(4)) f1 ();

  fifo_mxn_stream #(
    .DW(8), .AW(4), .AFULL_THR(12), .AEMPTY_THR(2), .STROBE_MODE(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (f0)
  );

  fifo_mxn_stream #(
    .DW(8), .AW(4), .AFULL_THR(12), .AEMPTY_THR(2), .STROBE_MODE(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (f1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every odat_vld pulse must match the next queued value
  always @(negedge clk) begin
    logic [7:0] e;
    if (f0.odat_vld) begin
      n_cmp++;
      if (exp0.size() == 0) begin
        n_bad++;
        $display("FAIL sb0_extra: got %0h required none", f0.odat);
      end else begin
        e = exp0.pop_front();
        if (f0.odat !== e) begin
          n_bad++;
          $display("FAIL sb0_odat: got %0h required %0h", f0.odat, e);
        end
      end
    end
    if (f1.odat_vld) begin
      n_cmp++;
      if (exp1.size() == 0) begin
        n_bad++;
        $display("FAIL sb1_extra: got %0h required none", f1.odat);
      end else begin
        e = exp1.pop_front();
        if (f1.odat !== e) begin
          n_bad++;
          $display("FAIL sb1_odat: got %0h required %0h", f1.odat, e);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    f0.ien  = 1'b0;
    f0.oen  = 1'b0;
    f0.idat = '0;
    f1.ien  = 1'b0;
    f1.oen  = 1'b0;
    f1.idat = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_level",  f0.level,    0);
    chk("rst_empty",  f0.empty,    1);
    chk("rst_full",   f0.full,     0);
    chk("rst_afull",  f0.afull,    0);
    chk("rst_aempty", f0.aempty,   1);
    chk("rst_odat",   f0.odat,     0);
    chk("rst_vld",    f0.odat_vld, 0);

    // Test 1: fill 0x00..0x0F, then a rejected 17th push
    for (int i = 0; i < 16; i++) begin
      f0.ien  = 1'b1;
      f0.idat = 8'(i);
      exp0.push_back(8'(i));
      tick();
      chk("fill_level", f0.level, i + 1);
      chk("fill_afull", f0.afull, (i + 1 >= 12) ? 1 : 0);
    end
    f0.idat = 8'hAA;
    tick();
    f0.ien = 1'b0;
    chk("ovf_level", f0.level, 16);
    chk("ovf_full",  f0.full,  1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag",  f0.ovf,   1);
`endif

    // Test 2: 16 isolated pops, then one extra on empty
    for (int i = 0; i < 16; i++) begin
      f0.oen = 1'b1;
      tick();
      f0.oen = 1'b0;
      chk("pop_vld_hi", f0.odat_vld, 1);
      tick();
      chk("pop_vld_lo", f0.odat_vld, 0);
    end
    chk("drain_empty", f0.empty, 1);
    f0.oen = 1'b1;
    tick();
    f0.oen = 1'b0;
    chk("udf_odat",  f0.odat,     8'h0F);
    chk("udf_vld",   f0.odat_vld, 0);
    chk("udf_level", f0.level,    0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_flag",  f0.udf,      1);
`endif

    // Test 3: fill, then 20 cycles of push+pop across the wrap
    for (int i = 0; i < 16; i++) begin
      f0.ien  = 1'b1;
      f0.idat = 8'(i);
      exp0.push_back(8'(i));
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      f0.ien  = 1'b1;
      f0.oen  = 1'b1;
      f0.idat = 8'(8'h10 + k);
      exp0.push_back(8'(8'h10 + k));
      tick();
      chk("both_level", f0.level, 16);
    end
    f0.ien = 1'b0;
    repeat (16) tick();
    f0.oen = 1'b0;
    tick();
    chk("both_empty", f0.empty, 1);

    // Test 5: clr with a simultaneous push at level 9
    for (int i = 0; i < 9; i++) begin
      f0.ien  = 1'b1;
      f0.idat = 8'(8'h40 + i);
      tick();
    end
    f0.ien = 1'b0;
    chk("pre_clr_level", f0.level, 9);
    clr     = 1'b1;
    f0.ien  = 1'b1;
    f0.idat = 8'h77;
    tick();
    clr    = 1'b0;
    f0.ien = 1'b0;
    chk("clr_level",  f0.level,    0);
    chk("clr_empty",  f0.empty,    1);
    chk("clr_aempty", f0.aempty,   1);
    chk("clr_odat",   f0.odat,     8'h23);
    chk("clr_vld",    f0.odat_vld, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("clr_ovf",    f0.ovf,      0);
    chk("clr_udf",    f0.udf,      0);
`endif
    f0.ien  = 1'b1;
    f0.idat = 8'h55;
    exp0.push_back(8'h55);
    tick();
    f0.ien = 1'b0;
    f0.oen = 1'b1;
    tick();
    f0.oen = 1'b0;
    tick();
    chk("post_clr_level", f0.level, 0);

    // Test 4: falling-edge strobe on the mode-1 instance
    f1.ien  = 1'b1;
    f1.idat = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fall_hold_level", f1.level, 0);
    end
    f1.ien = 1'b0;
    exp1.push_back(8'h5A);
    tick();
    chk("fall_level_e1", f1.level, 1);
    tick();
    chk("fall_level_e2", f1.level, 1);
    repeat (3) tick();
    chk("fall_once", f1.level, 1);
    f1.oen = 1'b1;
    repeat (2) tick();
    f1.oen = 1'b0;
    chk("fall_pop_wait", f1.level, 1);
    tick();
    tick();
    chk("fall_pop_empty", f1.empty, 1);

    // Test 6: reset mid-stream with ien/oen active
    f0.ien  = 1'b1;
    f0.idat = 8'h33;
    exp0.push_back(8'h33);
    tick();
    f0.ien = 1'b0;
    f0.oen = 1'b1;
    tick();
    f0.oen = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      f0.ien  = 1'b1;
      f0.idat = 8'(8'h60 + i);
      tick();
    end
    f0.ien = 1'b0;
    chk("pre_rst_level", f0.level, 7);
    chk("pre_rst_odat",  f0.odat,  8'h33);
    rst     = 1'b1;
    f0.ien  = 1'b1;
    f0.oen  = 1'b1;
    f0.idat = 8'h99;
    tick();
    rst    = 1'b0;
    f0.ien = 1'b0;
    f0.oen = 1'b0;
    chk("mid_rst_odat",  f0.odat,     0);
    chk("mid_rst_vld",   f0.odat_vld, 0);
    chk("mid_rst_level", f0.level,    0);
    chk("mid_rst_empty", f0.empty,    1);
    chk("mid_rst_full",  f0.full,     0);
    chk("mid_rst_afull", f0.afull,    0);
    repeat (2) tick();

    chk("sb0_left", exp0.size(), 0);
    chk("sb1_left", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
